// File: rtl/adc_sample_packer.sv
// adc_sample_packer
// -----------------
// Decimates a one-sample-per-clock ADC stream and packs SPW accepted samples,
// plus two status bits, into each FIFO write word. Capture ends after a
// programmed number of accepted samples or when capture_go_i drops. At the end
// of a capture, any partial word is flushed. A word that meets a full
// downstream FIFO is dropped, and that drop is recorded in a sticky flag.
//
// Word layout (k = 0 is the oldest sample):
//   [k*ADC_WIDTH +: ADC_WIDTH]  sample k
//   [WORD_WIDTH-1]              OR of adc_or over the samples in the word
//   [WORD_WIDTH-2]              adc_trig_status of the newest sample
//   all other bits              0
//
// Ports:
//   adc_sampleclk    sole clock, rising edge
//   reset_n_i        asynchronous active-low reset
//   adc_datain       ADC sample
//   adc_or           ADC over-range flag for this sample
//   adc_trig_status  trigger status for this sample
//   capture_go_i     level request; high starts and sustains a capture
//   max_samples_i    accepted-sample limit, latched at capture start
//   decimate_i       keep 1 of every decimate_i+1 samples, latched at start
//   fifo_full_i      downstream FIFO full
//   fifo_din_o       packed word
//   fifo_wr_en_o     one-cycle write strobe
//   fifo_last_o      marks the final word of a capture (only with wr_en)
//   fifo_slots_o     number of valid sample slots in the written word
//   capture_stop_o   high while flushing or done
//   capture_done_o   high when done
//   overflow_o       sticky: at least one word was dropped
//   samples_o        accepted-sample count
module adc_sample_packer #(
    parameter int ADC_WIDTH   = 10,
    parameter int WORD_WIDTH  = 32,
    parameter int CNT_WIDTH   = 32,
    parameter int DECIM_WIDTH = 16,
    localparam int SPW        = (WORD_WIDTH - 2) / ADC_WIDTH,
    localparam int SLOT_W     = $clog2(SPW + 1)
) (
    input  logic                   adc_sampleclk,
    input  logic                   reset_n_i,
    input  logic [ADC_WIDTH-1:0]   adc_datain,
    input  logic                   adc_or,
    input  logic                   adc_trig_status,
    input  logic                   capture_go_i,
    input  logic [CNT_WIDTH-1:0]   max_samples_i,
    input  logic [DECIM_WIDTH-1:0] decimate_i,
    input  logic                   fifo_full_i,
    output logic [WORD_WIDTH-1:0]  fifo_din_o,
    output logic                   fifo_wr_en_o,
    output logic                   fifo_last_o,
    output logic [SLOT_W-1:0]      fifo_slots_o,
    output logic                   capture_stop_o,
    output logic                   capture_done_o,
    output logic                   overflow_o,
    output logic [CNT_WIDTH-1:0]   samples_o
);

    generate
        if (SPW < 1) begin : g_spw_check
            $error("adc_sample_packer: WORD_WIDTH-2 cannot hold one ADC sample");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    state_e                 state_q,      state_d;
    logic [CNT_WIDTH-1:0]   limit_q,      limit_d;
    logic [DECIM_WIDTH-1:0] decim_q,      decim_d;
    logic [DECIM_WIDTH-1:0] dcnt_q,       dcnt_d;
    logic [SLOT_W-1:0]      slot_q,       slot_d;
    logic [WORD_WIDTH-1:0]  word_q,       word_d;
    logic [CNT_WIDTH-1:0]   samples_q,    samples_d;
    logic [WORD_WIDTH-1:0]  fifo_din_q,   fifo_din_d;
    logic                   fifo_wr_en_q, fifo_wr_en_d;
    logic                   fifo_last_q,  fifo_last_d;
    logic [SLOT_W-1:0]      fifo_slots_q, fifo_slots_d;
    logic                   stop_q,       stop_d;
    logic                   done_q,       done_d;
    logic                   overflow_q,   overflow_d;

    logic                   accept_s;
    logic                   stop_now_s;
    logic                   emit_s;
    logic                   emit_last_s;
    logic [WORD_WIDTH-1:0]  emit_word_s;
    logic [SLOT_W-1:0]      emit_slots_s;
    logic [WORD_WIDTH-1:0]  word_ins_s;

    // Insert one sample into its slot and refresh the status bits.
    // Unused slots are zero, so OR-ing the sample in is enough.
    function automatic logic [WORD_WIDTH-1:0] pack_sample(
        input logic [WORD_WIDTH-1:0] word,
        input logic [SLOT_W-1:0]     slot,
        input logic [ADC_WIDTH-1:0]  data,
        input logic                  ovr,
        input logic                  trig
    );
        logic [WORD_WIDTH-1:0] res;
        res = word | (WORD_WIDTH'(data) << (ADC_WIDTH * int'(slot)));
        res[WORD_WIDTH-1] = word[WORD_WIDTH-1] | ovr;
        res[WORD_WIDTH-2] = trig;
        return res;
    endfunction

    // State, datapath and output registers.
    always_ff @(posedge adc_sampleclk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= ST_IDLE;
            limit_q      <= '0;
            decim_q      <= '0;
            dcnt_q       <= '0;
            slot_q       <= '0;
            word_q       <= '0;
            samples_q    <= '0;
            fifo_din_q   <= '0;
            fifo_wr_en_q <= 1'b0;
            fifo_last_q  <= 1'b0;
            fifo_slots_q <= '0;
            stop_q       <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            limit_q      <= limit_d;
            decim_q      <= decim_d;
            dcnt_q       <= dcnt_d;
            slot_q       <= slot_d;
            word_q       <= word_d;
            samples_q    <= samples_d;
            fifo_din_q   <= fifo_din_d;
            fifo_wr_en_q <= fifo_wr_en_d;
            fifo_last_q  <= fifo_last_d;
            fifo_slots_q <= fifo_slots_d;
            stop_q       <= stop_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
        end
    end

    // Next-state, packing and write-issue logic.
    always_comb begin
        state_d      = state_q;
        limit_d      = limit_q;
        decim_d      = decim_q;
        dcnt_d       = dcnt_q;
        slot_d       = slot_q;
        word_d       = word_q;
        samples_d    = samples_q;
        fifo_din_d   = fifo_din_q;
        fifo_wr_en_d = 1'b0;
        fifo_last_d  = 1'b0;
        fifo_slots_d = fifo_slots_q;
        overflow_d   = overflow_q;
        accept_s     = 1'b0;
        stop_now_s   = 1'b0;
        emit_s       = 1'b0;
        emit_last_s  = 1'b0;
        emit_word_s  = '0;
        emit_slots_s = '0;
        word_ins_s   = pack_sample(word_q, slot_q, adc_datain, adc_or, adc_trig_status);

        case (state_q)
            ST_IDLE: begin
                if (capture_go_i) begin
                    limit_d    = max_samples_i;
                    decim_d    = decimate_i;
                    dcnt_d     = '0;
                    slot_d     = '0;
                    word_d     = '0;
                    samples_d  = '0;
                    overflow_d = 1'b0;
                    // A zero limit can never accept a sample, so skip straight to FLUSH.
                    if (max_samples_i == '0) begin
                        state_d = ST_FLUSH;
                    end else begin
                        state_d = ST_CAPTURE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_CAPTURE: begin
                accept_s = (dcnt_q == '0);
                if (dcnt_q == decim_q) begin
                    dcnt_d = '0;
                end else begin
                    dcnt_d = dcnt_q + DECIM_WIDTH'(1);
                end
                // The sample on the stopping edge is still accepted.
                stop_now_s = !capture_go_i ||
                             (accept_s && ((samples_q + CNT_WIDTH'(1)) == limit_q));
                if (accept_s) begin
                    samples_d = samples_q + CNT_WIDTH'(1);
                    if (slot_q == SLOT_W'(SPW - 1)) begin
                        // The word is complete. If this is also the final
                        // accept, it is the last word, and FLUSH has nothing
                        // left to write.
                        emit_s       = 1'b1;
                        emit_word_s  = word_ins_s;
                        emit_slots_s = SLOT_W'(SPW);
                        emit_last_s  = stop_now_s;
                        slot_d       = '0;
                        word_d       = '0;
                    end else begin
                        slot_d = slot_q + SLOT_W'(1);
                        word_d = word_ins_s;
                    end
                end else begin
                    samples_d = samples_q;
                end
                if (stop_now_s) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end

            ST_FLUSH: begin
                if (slot_q != '0) begin
                    emit_s       = 1'b1;
                    emit_word_s  = word_q;
                    emit_slots_s = slot_q;
                    emit_last_s  = 1'b1;
                end else begin
                    emit_s = 1'b0;
                end
                slot_d  = '0;
                word_d  = '0;
                state_d = ST_DONE;
            end

            ST_DONE: begin
                if (!capture_go_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A word that meets a full FIFO is dropped. Packing continues normally.
        if (emit_s) begin
            if (fifo_full_i) begin
                overflow_d = 1'b1;
            end else begin
                fifo_wr_en_d = 1'b1;
                fifo_din_d   = emit_word_s;
                fifo_last_d  = emit_last_s;
                fifo_slots_d = emit_slots_s;
            end
        end else begin
            fifo_wr_en_d = 1'b0;
        end
    end

    // Stop and done are registered from the next state, so they track the state register.
    always_comb begin
        stop_d = (state_d == ST_FLUSH) || (state_d == ST_DONE);
        done_d = (state_d == ST_DONE);
    end

    assign fifo_din_o     = fifo_din_q;
    assign fifo_wr_en_o   = fifo_wr_en_q;
    assign fifo_last_o    = fifo_last_q;
    assign fifo_slots_o   = fifo_slots_q;
    assign capture_stop_o = stop_q;
    assign capture_done_o = done_q;
    assign overflow_o     = overflow_q;
    assign samples_o      = samples_q;

endmodule

// File: tb/tb_adc_sample_packer.sv
// Scoreboard bench for adc_sample_packer with the default parameters.
// For each capture, a reference model derives the expected words from the
// stimulus tables. The model works from the accepted-sample list, chunks of
// SPW samples and the write-edge rule. A separate monitor pops and compares an
// expected word on every write strobe.
module tb_adc_sample_packer;

    localparam int ADC_W = 10;
    localparam int WW    = 32;
    localparam int CW    = 32;
    localparam int DW    = 16;
    localparam int SPW   = 3;
    localparam int SW    = 2;
    localparam int MAXC  = 66;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [ADC_W-1:0] adc_din;
    logic            adc_ovr;
    logic            adc_trig;
    logic            go;
    logic [CW-1:0]   max_samples;
    logic [DW-1:0]   decim;
    logic            fifo_full;
    logic [WW-1:0]   fifo_din;
    logic            fifo_wr_en;
    logic            fifo_last;
    logic [SW-1:0]   fifo_slots;
    logic            cap_stop;
    logic            cap_done;
    logic            overflow;
    logic [CW-1:0]   samples;

    typedef struct packed {
        logic [WW-1:0] word;
        logic          last;
        logic [SW-1:0] slots;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    adc_sample_packer dut (
        .adc_sampleclk   (clk),
        .reset_n_i       (reset_n),
        .adc_datain      (adc_din),
        .adc_or          (adc_ovr),
        .adc_trig_status (adc_trig),
        .capture_go_i    (go),
        .max_samples_i   (max_samples),
        .decimate_i      (decim),
        .fifo_full_i     (fifo_full),
        .fifo_din_o      (fifo_din),
        .fifo_wr_en_o    (fifo_wr_en),
        .fifo_last_o     (fifo_last),
        .fifo_slots_o    (fifo_slots),
        .capture_stop_o  (cap_stop),
        .capture_done_o  (cap_done),
        .overflow_o      (overflow),
        .samples_o       (samples)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected word.
    always @(negedge clk) begin
        if (reset_n && fifo_wr_en) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write actual=%h required=no_write", fifo_din);
            end else begin
                mon_e = sb.pop_front();
                chk("word",  64'(fifo_din),   64'(mon_e.word));
                chk("last",  64'(fifo_last),  64'(mon_e.last));
                chk("slots", 64'(fifo_slots), 64'(mon_e.slots));
            end
        end
    end

    // One complete capture. The task is entered and left at a falling edge.
    // ramp >= 0: data = ramp + capture-edge index; otherwise random data.
    // or_edge: edge index carrying adc_or=1, or -2 for random over-range.
    task automatic run_test(input int dec, input int limit, input int go_len,
                            input int full_lo, input int full_hi,
                            input int ramp, input int or_edge);
        logic [ADC_W-1:0] d [MAXC];
        logic o [MAXC];
        logic t [MAXC];
        logic f [MAXC];
        int   acc_c[$];
        int   s, n, k, wedge;
        logic ovf, any_or, lst;
        logic [WW-1:0] w;
        exp_t e;

        for (int c = 0; c < MAXC; c++) begin
            d[c] = (ramp >= 0) ? ADC_W'(ramp + c) : ADC_W'($urandom);
            o[c] = (or_edge == -2) ? ($urandom_range(0, 3) == 0) : (c == or_edge);
            t[c] = 1'($urandom);
            f[c] = (c >= full_lo) && (c <= full_hi);
        end

        // Reference model: which capture edges accept, and where capture stops.
        s = -1;
        if (limit > 0) begin
            for (int c = 0; c < MAXC - 1; c++) begin
                if (c % (dec + 1) == 0) acc_c.push_back(c);
                if (((c % (dec + 1) == 0) && (acc_c.size() == limit)) || (c >= go_len)) begin
                    s = c;
                    break;
                end
            end
        end
        n   = acc_c.size();
        ovf = 1'b0;
        for (int b = 0; b < n; b += SPW) begin
            k      = (n - b < SPW) ? (n - b) : SPW;
            w      = '0;
            any_or = 1'b0;
            for (int j = 0; j < k; j++) begin
                w      = w | (WW'(d[acc_c[b + j]]) << (ADC_W * j));
                any_or = any_or | o[acc_c[b + j]];
            end
            w[WW-1] = any_or;
            w[WW-2] = t[acc_c[b + k - 1]];
            // Full words go out on the edge of their last accept; a partial word goes out on the FLUSH edge.
            wedge = (k == SPW) ? acc_c[b + k - 1] : s + 1;
            lst   = (b + k == n) && ((k < SPW) || (acc_c[b + k - 1] == s));
            if (f[wedge]) begin
                ovf = 1'b1;
            end else begin
                e.word  = w;
                e.last  = lst;
                e.slots = SW'(k);
                sb.push_back(e);
            end
        end

        go          = 1'b1;
        max_samples = CW'(limit);
        decim       = DW'(dec);
        fifo_full   = 1'b0;
        @(posedge clk);
        for (int c = 0; c <= s; c++) begin
            @(negedge clk);
            adc_din   = d[c];
            adc_ovr   = o[c];
            adc_trig  = t[c];
            fifo_full = f[c];
            go        = (c < go_len);
            @(posedge clk);
        end
        @(negedge clk);
        chk("stop_in_flush", 64'(cap_stop), 64'd1);
        chk("done_in_flush", 64'(cap_done), 64'd0);
        fifo_full = f[s + 1];
        @(posedge clk);
        @(negedge clk);
        chk("done",         64'(cap_done), 64'd1);
        chk("stop_in_done", 64'(cap_stop), 64'd1);
        chk("samples",      64'(samples),  64'(n));
        chk("overflow",     64'(overflow), 64'(ovf));
        go        = 1'b0;
        fifo_full = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("done_idle",     64'(cap_done), 64'd0);
        chk("stop_idle",     64'(cap_stop), 64'd0);
        chk("overflow_idle", 64'(overflow), 64'(ovf));
        chk("pending_words", 64'(sb.size()), 64'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_din"},     64'(fifo_din),   64'd0);
        chk({tag, "_wr_en"},   64'(fifo_wr_en), 64'd0);
        chk({tag, "_last"},    64'(fifo_last),  64'd0);
        chk({tag, "_slots"},   64'(fifo_slots), 64'd0);
        chk({tag, "_stop"},    64'(cap_stop),   64'd0);
        chk({tag, "_done"},    64'(cap_done),   64'd0);
        chk({tag, "_ovf"},     64'(overflow),   64'd0);
        chk({tag, "_samples"}, 64'(samples),    64'd0);
    endtask

    initial begin
        int fl;
        reset_n     = 1'b0;
        adc_din     = '0;
        adc_ovr     = 1'b0;
        adc_trig    = 1'b0;
        go          = 1'b0;
        max_samples = '0;
        decim       = '0;
        fifo_full   = 1'b0;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed cases from the capture scenarios.
        run_test(0, 6, 1000, 1000, 1000, 1, -1);   // two full words, second is last
        run_test(0, 7, 1000, 1000, 1000, 1, -1);   // partial third word, slots=1
        run_test(2, 3, 1000, 1000, 1000, 0, -1);   // decimate: samples 0,3,6
        run_test(0, 6, 1000, 1000, 1000, 1, 2);    // over-range only in word 0
        run_test(0, 6, 1000, 1, 3, 1, -1);        // first word dropped, overflow sticky
        run_test(0, 6, 1000, 1000, 1000, 1, -1);   // overflow cleared on new capture
        run_test(0, 0, 1000, 1000, 1000, 1, -1);   // zero limit
        run_test(0, 20, 3, 1000, 1000, 1, -1);     // go drops on the 4th accept
        run_test(3, 20, 5, 1000, 1000, 5, -1);     // go drops mid-decimation

        // Randomized captures.
        for (int i = 0; i < 30; i++) begin
            fl = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 40)) : 1000;
            run_test(int'($urandom_range(0, 3)), int'($urandom_range(0, 12)),
                     ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 30)) : 1000,
                     fl, fl + int'($urandom_range(0, 4)), -1, -2);
        end

        // Reset mid-capture: outputs clear at once and the partial word is lost.
        go          = 1'b1;
        max_samples = CW'(10);
        decim       = '0;
        @(posedge clk);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            adc_din = ADC_W'(c + 1);
            @(posedge clk);
        end
        @(negedge clk);
        chk("pre_reset_samples", 64'(samples), 64'd2);
        reset_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        go = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_test(1, 5, 1000, 1000, 1000, 100, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
